// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusD,
    StBusI,
    StResp
  } arb_state_e;

  localparam int unsigned TimeoutDefault = 255;
  localparam logic [31:0] NopInstr       = 32'h0000_0013;
  localparam logic [3:0]  BeAll          = 4'hF;

  function automatic logic is_bus_state(arb_state_e s);
    return (s == StBusD) || (s == StBusI);
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Bus watchdog: counts bus cycles without mem_ready and pulses timeout_o on the last allowed one.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned Timeout = TimeoutDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_en_i,
  output logic timeout_o
);

  localparam int unsigned    CntW    = $clog2(Timeout + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && (cnt_q != CntLast)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires in the cycle that would make the stall count reach Timeout.
  assign timeout_o = count_en_i && (cnt_q == CntLast);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access; data has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_be_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        mem_valid_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        if_done_o,
  output logic [31:0] if_rdata_o,
  output logic        dm_done_o,
  output logic [31:0] dm_rdata_o,
  output logic        stall_f_o,
  output logic        stall_m_o,
  output logic        err_o
);

  arb_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        own_dm_q, own_dm_d;
  logic        discard_q, discard_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        err_q, err_d;

  logic in_bus;
  logic wd_clear, wd_count, wd_timeout;

  assign in_bus   = is_bus_state(state_q);
  assign wd_count = in_bus && !mem_ready_i;

  mem_arb_watchdog #(
    .Timeout(TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (wd_clear),
    .count_en_i(wd_count),
    .timeout_o (wd_timeout)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    own_dm_d   = own_dm_q;
    discard_d  = discard_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    err_d      = err_q;
    wd_clear   = 1'b0;

    unique case (state_q)
      StIdle: begin
        discard_d = 1'b0;
        if (dm_req_i) begin
          state_d  = StBusD;
          addr_d   = dm_addr_i;
          we_d     = dm_we_i;
          be_d     = dm_be_i;
          wdata_d  = dm_wdata_i;
          own_dm_d = 1'b1;
          wd_clear = 1'b1;
        end else if (if_req_i) begin
          state_d   = StBusI;
          addr_d    = if_addr_i;
          we_d      = 1'b0;
          be_d      = BeAll;
          wdata_d   = '0;
          own_dm_d  = 1'b0;
          discard_d = if_flush_i;
          wd_clear  = 1'b1;
        end
      end
      StBusD, StBusI: begin
        if ((state_q == StBusI) && if_flush_i) begin
          discard_d = 1'b1;
        end
        if (mem_ready_i) begin
          state_d = StResp;
          if (state_q == StBusD) begin
            dm_rdata_d = mem_rdata_i;
          end else begin
            if_rdata_d = mem_rdata_i;
          end
        end else if (wd_timeout) begin
          // Give up on the bus; fetch sees a NOP so the pipeline keeps moving.
          state_d = StResp;
          err_d   = 1'b1;
          if (state_q == StBusD) begin
            dm_rdata_d = '0;
          end else begin
            if_rdata_d = NopInstr;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      own_dm_q   <= 1'b0;
      discard_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      own_dm_q   <= own_dm_d;
      discard_q  <= discard_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      err_q      <= err_d;
    end
  end

  assign mem_valid_o = in_bus;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  // A flush arriving in the response cycle still kills the fetch completion.
  assign if_done_o  = (state_q == StResp) && !own_dm_q && !discard_q && !if_flush_i;
  assign dm_done_o  = (state_q == StResp) && own_dm_q;
  assign if_rdata_o = if_rdata_q;
  assign dm_rdata_o = dm_rdata_q;

  assign stall_f_o = if_req_i & ~if_done_o;
  assign stall_m_o = dm_req_i & ~dm_done_o;
  assign err_o     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences, random traffic.
module tb_mem_arbiter;

  localparam int unsigned To = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [3:0]  dm_be_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        mem_valid_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic        if_done_o;
  logic [31:0] if_rdata_o;
  logic        dm_done_o;
  logic [31:0] dm_rdata_o;
  logic        stall_f_o;
  logic        stall_m_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(
    .TIMEOUT(To)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_flush_i (if_flush_i),
    .dm_req_i   (dm_req_i),
    .dm_we_i    (dm_we_i),
    .dm_be_i    (dm_be_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .mem_valid_o(mem_valid_o),
    .mem_we_o   (mem_we_o),
    .mem_be_o   (mem_be_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i),
    .if_done_o  (if_done_o),
    .if_rdata_o (if_rdata_o),
    .dm_done_o  (dm_done_o),
    .dm_rdata_o (dm_rdata_o),
    .stall_f_o  (stall_f_o),
    .stall_m_o  (stall_m_o),
    .err_o      (err_o)
  );

  typedef struct {
    bit          is_dm;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    bit          if_en;
    bit          dm_en;
    logic [31:0] if_addr;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    int          d_delay;
    int          i_delay;
    logic [31:0] d_rdata;
    logic [31:0] i_rdata;
    bit          exp_dm_first;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_if_rd = '0;
  logic [31:0] last_dm_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk_fetch(logic [31:0] addr, int delay, logic [31:0] rdata);
    txn_t t;
    t.is_dm = 1'b0;
    t.addr  = addr;
    t.we    = 1'b0;
    t.be    = 4'hF;
    t.wdata = 32'h0;
    t.delay = delay;
    t.rdata = rdata;
    return t;
  endfunction

  function automatic txn_t mk_data(logic we, logic [3:0] be, logic [31:0] addr,
                                   logic [31:0] wdata, int delay, logic [31:0] rdata);
    txn_t t;
    t.is_dm = 1'b1;
    t.addr  = addr;
    t.we    = we;
    t.be    = be;
    t.wdata = wdata;
    t.delay = delay;
    t.rdata = rdata;
    return t;
  endfunction

  // Entered at posedge+1 of an IDLE cycle with the request already driven.
  task automatic serve(input txn_t t);
    @(negedge clk_i);
    chk("idle_valid", 32'(mem_valid_o), 32'd0);
    chk("stall_wait", 32'(t.is_dm ? stall_m_o : stall_f_o), 32'd1);
    for (int d = 0; d <= t.delay; d++) begin
      @(posedge clk_i); #1;
      mem_ready_i = (d == t.delay);
      mem_rdata_i = (d == t.delay) ? t.rdata : $urandom;
      @(negedge clk_i);
      chk("bus_valid", 32'(mem_valid_o), 32'd1);
      chk("bus_addr", mem_addr_o, t.addr);
      chk("bus_we", 32'(mem_we_o), 32'(t.we));
      chk("bus_be", 32'(mem_be_o), 32'(t.be));
      chk("bus_wdata", mem_wdata_o, t.wdata);
      chk("bus_no_done", 32'(if_done_o | dm_done_o), 32'd0);
      if (t.is_dm) chk("if_rdata_hold", if_rdata_o, last_if_rd);
      else         chk("dm_rdata_hold", dm_rdata_o, last_dm_rd);
    end
    @(posedge clk_i); #1;
    mem_ready_i = 1'($urandom);
    mem_rdata_i = $urandom;
    @(negedge clk_i);
    chk("done", 32'(t.is_dm ? dm_done_o : if_done_o), 32'd1);
    chk("other_done", 32'(t.is_dm ? if_done_o : dm_done_o), 32'd0);
    chk("rdata", t.is_dm ? dm_rdata_o : if_rdata_o, t.rdata);
    chk("stall_done", 32'(t.is_dm ? stall_m_o : stall_f_o), 32'd0);
    chk("resp_valid", 32'(mem_valid_o), 32'd0);
    if (t.is_dm) last_dm_rd = t.rdata;
    else         last_if_rd = t.rdata;
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0;
    if (t.is_dm) dm_req_i = 1'b0;
    else         if_req_i = 1'b0;
  endtask

  task automatic drive_reqs(input bit if_en, input txn_t ti, input bit dm_en, input txn_t td);
    if_req_i   = if_en;
    if_addr_i  = ti.addr;
    dm_req_i   = dm_en;
    dm_we_i    = td.we;
    dm_be_i    = td.be;
    dm_addr_i  = td.addr;
    dm_wdata_i = td.wdata;
  endtask

  // Fetch with a flush at phase 0 (accept), 1 (first bus cycle) or 2 (response cycle).
  task automatic flush_seq(input int phase, input int delay, input logic [31:0] addr);
    if_req_i   = 1'b1;
    if_addr_i  = addr;
    if_flush_i = (phase == 0);
    @(negedge clk_i);
    chk("fl_idle_valid", 32'(mem_valid_o), 32'd0);
    @(posedge clk_i); #1;
    if_flush_i = (phase == 1);
    for (int d = 0; d <= delay; d++) begin
      mem_ready_i = (d == delay);
      mem_rdata_i = 32'hBAD0_0000 | 32'(d);
      @(negedge clk_i);
      chk("fl_bus_valid", 32'(mem_valid_o), 32'd1);
      chk("fl_bus_addr", mem_addr_o, addr);
      @(posedge clk_i); #1;
      if_flush_i = 1'b0;
    end
    mem_ready_i = 1'b0;
    if_flush_i  = (phase == 2);
    @(negedge clk_i);
    chk("fl_no_done", 32'(if_done_o), 32'd0);
    chk("fl_stall", 32'(stall_f_o), 32'd1);
    last_if_rd = 32'hBAD0_0000 | 32'(delay);
    @(posedge clk_i); #1;
    if_flush_i = 1'b0;
    if_req_i   = 1'b0;
  endtask

  // Transaction that never sees mem_ready; expects TO bus cycles then forced completion.
  task automatic timeout_seq(input bit is_dm);
    if (is_dm) begin
      dm_req_i  = 1'b1;
      dm_we_i   = 1'b0;
      dm_be_i   = 4'hF;
      dm_addr_i = 32'h0000_5000;
    end else begin
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0400;
    end
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    for (int k = 1; k <= int'(To); k++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("to_bus_valid", 32'(mem_valid_o), 32'd1);
      chk("to_no_done", 32'(if_done_o | dm_done_o), 32'd0);
      if (!is_dm) chk("to_err_low", 32'(err_o), 32'd0);
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("to_done", 32'(is_dm ? dm_done_o : if_done_o), 32'd1);
    chk("to_rdata", is_dm ? dm_rdata_o : if_rdata_o, is_dm ? 32'h0 : 32'h0000_0013);
    chk("to_err", 32'(err_o), 32'd1);
    if (is_dm) last_dm_rd = 32'h0;
    else       last_if_rd = 32'h0000_0013;
    @(posedge clk_i); #1;
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    @(negedge clk_i);
    chk("to_err_sticky", 32'(err_o), 32'd1);
    @(posedge clk_i); #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_valid", 32'(mem_valid_o), 32'd0);
    chk("rst_if_done", 32'(if_done_o), 32'd0);
    chk("rst_dm_done", 32'(dm_done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_dm_rdata", dm_rdata_o, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_be", 32'(mem_be_o), 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
  endtask

  vec_t vecs[6];
  txn_t q[$];

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got running, want finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst_i       = 1'b1;
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    if_flush_i  = 1'b0;
    dm_req_i    = 1'b0;
    dm_we_i     = 1'b0;
    dm_be_i     = '0;
    dm_addr_i   = '0;
    dm_wdata_i  = '0;
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;

    vecs[0] = '{1, 0, 32'h100, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0050_0093, 0};
    vecs[1] = '{1, 1, 32'h104, 1, 4'hF, 32'h2000, 32'hDEAD_BEEF, 0, 0, 32'h1111_2222,
                32'h0000_0033, 1};
    vecs[2] = '{0, 1, 32'h0, 0, 4'h3, 32'h3004, 32'h0, 2, 0, 32'hCAFE_F00D, 32'h0, 1};
    vecs[3] = '{1, 1, 32'h108, 0, 4'hC, 32'h3008, 32'h5555_AAAA, 1, 2, 32'h1234_5678,
                32'h00A0_0113, 1};
    vecs[4] = '{1, 0, 32'h10C, 0, 4'h0, 32'h0, 32'h0, 0, 3, 32'h0, 32'hFFFF_FFFF, 0};
    vecs[5] = '{0, 1, 32'h0, 1, 4'h8, 32'h300C, 32'hA5A5_5A5A, 0, 0, 32'h0BAD_BEEF, 32'h0, 1};

    repeat (3) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk_reset_outputs();
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Directed vectors.
    foreach (vecs[i]) begin
      txn_t ti, td;
      ti = mk_fetch(vecs[i].if_addr, vecs[i].i_delay, vecs[i].i_rdata);
      td = mk_data(vecs[i].dm_we, vecs[i].dm_be, vecs[i].dm_addr, vecs[i].dm_wdata,
                   vecs[i].d_delay, vecs[i].d_rdata);
      drive_reqs(vecs[i].if_en, ti, vecs[i].dm_en, td);
      if (vecs[i].if_en && vecs[i].dm_en) begin
        if (vecs[i].exp_dm_first) begin
          serve(td);
          serve(ti);
        end else begin
          serve(ti);
          serve(td);
        end
      end else if (vecs[i].dm_en) begin
        serve(td);
      end else begin
        serve(ti);
      end
    end

    // Flush corner cases, then a clean fetch to the next word.
    flush_seq(1, 3, 32'h0000_0200);
    begin
      txn_t ti, td;
      ti = mk_fetch(32'h0000_0204, 0, 32'h0010_0073);
      td = mk_data(0, 4'h0, 32'h0, 32'h0, 0, 32'h0);
      drive_reqs(1, ti, 0, td);
      serve(ti);
    end
    flush_seq(0, 1, 32'h0000_0208);
    flush_seq(2, 0, 32'h0000_020C);

    // Flush must not disturb a data transaction.
    begin
      txn_t ti, td;
      ti = mk_fetch(32'h0, 0, 32'h0);
      td = mk_data(0, 4'hF, 32'h0000_6000, 32'h0, 1, 32'h7777_8888);
      drive_reqs(0, ti, 1, td);
      if_flush_i = 1'b1;
      serve(td);
      if_flush_i = 1'b0;
    end

    // Random traffic against a transaction-level priority model.
    for (int n = 0; n < 40; n++) begin
      txn_t ti, td;
      bit   if_en, dm_en;
      if_en = 1'($urandom);
      dm_en = 1'($urandom);
      if (!if_en && !dm_en) if_en = 1'b1;
      ti = mk_fetch($urandom, int'($urandom_range(0, 3)), $urandom);
      td = mk_data(1'($urandom), 4'($urandom), $urandom, $urandom,
                   int'($urandom_range(0, 3)), $urandom);
      drive_reqs(if_en, ti, dm_en, td);
      if (dm_en) q.push_back(td);
      if (if_en) q.push_back(ti);
      while (q.size() > 0) serve(q.pop_front());
    end

    timeout_seq(0);
    timeout_seq(1);

    // Reset in the middle of a data bus cycle.
    dm_req_i   = 1'b1;
    dm_we_i    = 1'b1;
    dm_be_i    = 4'hF;
    dm_addr_i  = 32'h0000_2000;
    dm_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("pre_rst_valid", 32'(mem_valid_o), 32'd1);
    @(posedge clk_i); #1;
    rst_i    = 1'b1;
    dm_req_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk_reset_outputs();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("post_rst_no_done", 32'(dm_done_o | if_done_o), 32'd0);
      chk("post_rst_valid", 32'(mem_valid_o), 32'd0);
      @(posedge clk_i); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
